// File: rtl/tomasulo_rs.sv
// Tomasulo reservation station: N entries, CDB wakeup with dispatch bypass, oldest-ready issue.
// Define TOMASULO_RS_OCC_EN to add the registered occupancy output occ.
module tomasulo_rs #(
  parameter int unsigned N      = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_vld,
  output logic              disp_rdy,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_dst_tag,
  input  logic              disp_s0_rdy,
  input  logic              disp_s1_rdy,
  input  logic [TAG_W-1:0]  disp_s0_tag,
  input  logic [TAG_W-1:0]  disp_s1_tag,
  input  logic [DATA_W-1:0] disp_s0_data,
  input  logic [DATA_W-1:0] disp_s1_data,
  input  logic              cdb_vld,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_vld,
  output logic [OP_W-1:0]   iss_op,
  output logic [TAG_W-1:0]  iss_tag,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b
`ifdef TOMASULO_RS_OCC_EN
  ,
  output logic [$clog2(N+1)-1:0] occ
`endif
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OCC_W = $clog2(N + 1);

  logic [N-1:0]      r_vld;
  logic [N-1:0]      r_s0_rdy;
  logic [N-1:0]      r_s1_rdy;
  logic [OP_W-1:0]   r_op      [N];
  logic [TAG_W-1:0]  r_dst     [N];
  logic [TAG_W-1:0]  r_s0_tag  [N];
  logic [TAG_W-1:0]  r_s1_tag  [N];
  logic [DATA_W-1:0] r_s0_data [N];
  logic [DATA_W-1:0] r_s1_data [N];
  logic [N-1:0]      r_age     [N];  // r_age[i][j]: entry i is older than entry j

  logic              r_iss_vld;
  logic [OP_W-1:0]   r_iss_op;
  logic [TAG_W-1:0]  r_iss_tag;
  logic [DATA_W-1:0] r_iss_a;
  logic [DATA_W-1:0] r_iss_b;

  logic [N-1:0]      w_elig;
  logic [N-1:0]      w_sel;
  logic [N-1:0]      w_wake0;
  logic [N-1:0]      w_wake1;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_disp;
  logic              w_any_sel;
  logic              w_byp0;
  logic              w_byp1;
  logic [OP_W-1:0]   w_sel_op;
  logic [TAG_W-1:0]  w_sel_tag;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;

  assign disp_rdy  = ~(&r_vld);
  assign w_disp    = disp_vld & disp_rdy;
  assign w_elig    = r_vld & r_s0_rdy & r_s1_rdy;
  assign w_any_sel = |w_elig;
  assign w_byp0    = cdb_vld & ~disp_s0_rdy & (disp_s0_tag == cdb_tag);
  assign w_byp1    = cdb_vld & ~disp_s1_rdy & (disp_s1_tag == cdb_tag);

  // Oldest eligible entry wins; CDB tag match per waiting source
  always_comb begin
    w_sel   = '0;
    w_wake0 = '0;
    w_wake1 = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_sel[i] = w_elig[i];
      for (int j = 0; j < int'(N); j++) begin
        if (j != i && w_elig[j] && r_age[j][i]) w_sel[i] = 1'b0;
      end
      w_wake0[i] = cdb_vld & r_vld[i] & ~r_s0_rdy[i] & (r_s0_tag[i] == cdb_tag);
      w_wake1[i] = cdb_vld & r_vld[i] & ~r_s1_rdy[i] & (r_s1_tag[i] == cdb_tag);
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!r_vld[i]) w_free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_sel_op  = '0;
    w_sel_tag = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_sel[i]) begin
        w_sel_op  = r_op[i];
        w_sel_tag = r_dst[i];
        w_sel_a   = r_s0_data[i];
        w_sel_b   = r_s1_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld     <= '0;
      r_s0_rdy  <= '0;
      r_s1_rdy  <= '0;
      for (int i = 0; i < int'(N); i++) begin
        r_op[i]      <= '0;
        r_dst[i]     <= '0;
        r_s0_tag[i]  <= '0;
        r_s1_tag[i]  <= '0;
        r_s0_data[i] <= '0;
        r_s1_data[i] <= '0;
        r_age[i]     <= '0;
      end
      r_iss_vld <= 1'b0;
      r_iss_op  <= '0;
      r_iss_tag <= '0;
      r_iss_a   <= '0;
      r_iss_b   <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (w_sel[i]) r_vld[i] <= 1'b0;
        if (w_wake0[i]) begin
          r_s0_rdy[i]  <= 1'b1;
          r_s0_data[i] <= cdb_data;
        end
        if (w_wake1[i]) begin
          r_s1_rdy[i]  <= 1'b1;
          r_s1_data[i] <= cdb_data;
        end
      end
      // New entry is younger than every currently valid entry
      if (w_disp) begin
        r_vld[w_free_idx]     <= 1'b1;
        r_op[w_free_idx]      <= disp_op;
        r_dst[w_free_idx]     <= disp_dst_tag;
        r_s0_rdy[w_free_idx]  <= disp_s0_rdy | w_byp0;
        r_s1_rdy[w_free_idx]  <= disp_s1_rdy | w_byp1;
        r_s0_tag[w_free_idx]  <= disp_s0_tag;
        r_s1_tag[w_free_idx]  <= disp_s1_tag;
        r_s0_data[w_free_idx] <= w_byp0 ? cdb_data : disp_s0_data;
        r_s1_data[w_free_idx] <= w_byp1 ? cdb_data : disp_s1_data;
        for (int j = 0; j < int'(N); j++) begin
          r_age[j][w_free_idx] <= r_vld[j];
        end
        r_age[w_free_idx] <= '0;
      end
      r_iss_vld <= w_any_sel;
      if (w_any_sel) begin
        r_iss_op  <= w_sel_op;
        r_iss_tag <= w_sel_tag;
        r_iss_a   <= w_sel_a;
        r_iss_b   <= w_sel_b;
      end
    end
  end

  assign iss_vld = r_iss_vld;
  assign iss_op  = r_iss_op;
  assign iss_tag = r_iss_tag;
  assign iss_a   = r_iss_a;
  assign iss_b   = r_iss_b;

`ifdef TOMASULO_RS_OCC_EN
  logic [OCC_W-1:0] r_occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_occ <= '0;
    else      r_occ <= r_occ + OCC_W'(w_disp) - OCC_W'(w_any_sel);
  end

  assign occ = r_occ;
`endif

endmodule
